// File: rtl/tic_tac_pkg.sv
// tic_tac_pkg: shared types and constants for the tic-tac-toe game controller.
//   state_t  : controller FSM states
//   result_t : game result code presented on result_o
//   cell_mask: one-hot board mask for a move position (zero when out of range)
package tic_tac_pkg;

   localparam int   BOARD_CELLS = 9;
   localparam logic PLAYER_X    = 1'b0;
   localparam logic PLAYER_O    = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_TURN,
      ST_CHECK,
      ST_DONE
   } state_t;

   typedef enum logic [2:0] {
      RES_NONE      = 3'd0,
      RES_X_WIN     = 3'd1,
      RES_O_WIN     = 3'd2,
      RES_DRAW      = 3'd3,
      RES_ERROR     = 3'd4,
      RES_TIMEOUT_X = 3'd5,
      RES_TIMEOUT_O = 3'd6
   } result_t;

   // Positions 9..15 do not address a cell; an all-zero mask marks them illegal.
   function automatic logic [BOARD_CELLS-1:0] cell_mask(input logic [3:0] pos);
      logic [BOARD_CELLS-1:0] mask;
      mask = '0;
      if (pos <= 4'd8) begin
         mask = BOARD_CELLS'(1) << pos;
      end
      return mask;
   endfunction

endpackage

// File: rtl/tic_tac_turn_timer.sv
// tic_tac_turn_timer: per-turn move timeout counter.
//   clk_i   : clock
//   rst_i   : asynchronous active-high reset
//   clear   : force the count to zero (takes priority over enable)
//   enable  : count this cycle
//   expired : count has reached TIMEOUT_CYCLES-1 (the last allowed cycle)
module tic_tac_turn_timer #(
   parameter int TIMEOUT_CYCLES = 1,
   parameter int TMR_W          = 16
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam logic [TMR_W-1:0] LAST = TMR_W'(TIMEOUT_CYCLES - 1);

   logic [TMR_W-1:0] count_reg;

   // The count saturates at LAST: an illegal move consumed on the last cycle
   // postpones the forfeit by one cycle instead of letting the count run past.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         count_reg <= '0;
      end else if (clear) begin
         count_reg <= '0;
      end else if (enable && (count_reg != LAST)) begin
         count_reg <= count_reg + TMR_W'(1);
      end
   end

   assign expired = (count_reg == LAST);

endmodule

// File: rtl/tic_tac_game_ctrl.sv
// tic_tac_game_ctrl: sequential tic-tac-toe game controller feeding a board
// evaluator.
//   start_i                : restart a game from any state (highest priority)
//   move_valid_i/move_pos_i: move offer; consumed when move_ready_o is high
//   move_ready_o           : controller is waiting for a move
//   move_reject_o          : one-cycle pulse after an illegal move was consumed
//   x_board_o/o_board_o    : cell occupancy, drive the evaluator x/o inputs
//   eval_*_i               : evaluator results, sampled in the CHECK state
//   turn_o, move_cnt_o     : player to move, legal moves placed
//   game_over_o, result_o  : game finished and its result code
module tic_tac_game_ctrl
   import tic_tac_pkg::*;
#(
   parameter logic FIRST_PLAYER   = 1'b0,
   parameter int   TIMEOUT_CYCLES = 0,
   parameter int   TMR_W          = 16
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       start_i,
   input  logic       move_valid_i,
   input  logic [3:0] move_pos_i,
   output logic       move_ready_o,
   output logic       move_reject_o,
   output logic [8:0] x_board_o,
   output logic [8:0] o_board_o,
   input  logic       eval_error_i,
   input  logic       eval_full_i,
   input  logic       eval_winx_i,
   input  logic       eval_wino_i,
   output logic       turn_o,
   output logic [3:0] move_cnt_o,
   output logic       game_over_o,
   output logic [2:0] result_o
);

   state_t     state_reg,    state_next;
   result_t    result_reg,   result_next;
   logic [8:0] x_board_reg,  x_board_next;
   logic [8:0] o_board_reg,  o_board_next;
   logic [3:0] move_cnt_reg, move_cnt_next;
   logic       turn_reg,     turn_next;
   logic       reject_reg,   reject_next;

   logic [8:0] pos_mask;
   logic       move_take;
   logic       move_legal;
   logic       legal_take;
   logic       timer_expired;

   assign move_ready_o = (state_reg == ST_TURN) && !start_i;
   assign move_take    = move_valid_i && move_ready_o;
   assign pos_mask     = cell_mask(move_pos_i);
   assign move_legal   = (pos_mask != 9'd0) && ((pos_mask & (x_board_reg | o_board_reg)) == 9'd0);
   assign legal_take   = move_take && move_legal;

   generate
      if (TIMEOUT_CYCLES > 0) begin : g_timer
         logic timer_clear;
         logic timer_enable;

         // Clearing whenever we are not in TURN guarantees a zero count on
         // every entry to TURN (from start or from CHECK).
         assign timer_clear  = start_i || (state_reg != ST_TURN);
         assign timer_enable = (state_reg == ST_TURN) && !legal_take;

         tic_tac_turn_timer #(
            .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
            .TMR_W         (TMR_W)
         ) u_turn_timer (
            .clk_i  (clk_i),
            .rst_i  (rst_i),
            .clear  (timer_clear),
            .enable (timer_enable),
            .expired(timer_expired)
         );
      end else begin : g_no_timer
         assign timer_expired = 1'b0;
      end
   endgenerate

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_reg    <= ST_IDLE;
         result_reg   <= RES_NONE;
         x_board_reg  <= '0;
         o_board_reg  <= '0;
         move_cnt_reg <= '0;
         turn_reg     <= FIRST_PLAYER;
         reject_reg   <= 1'b0;
      end else begin
         state_reg    <= state_next;
         result_reg   <= result_next;
         x_board_reg  <= x_board_next;
         o_board_reg  <= o_board_next;
         move_cnt_reg <= move_cnt_next;
         turn_reg     <= turn_next;
         reject_reg   <= reject_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      result_next   = result_reg;
      x_board_next  = x_board_reg;
      o_board_next  = o_board_reg;
      move_cnt_next = move_cnt_reg;
      turn_next     = turn_reg;
      reject_next   = 1'b0;

      if (start_i) begin
         state_next    = ST_TURN;
         result_next   = RES_NONE;
         x_board_next  = '0;
         o_board_next  = '0;
         move_cnt_next = '0;
         turn_next     = FIRST_PLAYER;
      end else begin
         unique case (state_reg)
            ST_IDLE: ;
            ST_TURN: begin
               if (move_take) begin
                  // Any consumed move, legal or not, pre-empts the timeout.
                  if (move_legal) begin
                     if (turn_reg == PLAYER_O) begin
                        o_board_next = o_board_reg | pos_mask;
                     end else begin
                        x_board_next = x_board_reg | pos_mask;
                     end
                     if (move_cnt_reg != 4'd9) begin
                        move_cnt_next = move_cnt_reg + 4'd1;
                     end
                     state_next = ST_CHECK;
                  end else begin
                     reject_next = 1'b1;
                  end
               end else if (timer_expired) begin
                  state_next  = ST_DONE;
                  result_next = (turn_reg == PLAYER_O) ? RES_TIMEOUT_O : RES_TIMEOUT_X;
               end
            end
            ST_CHECK: begin
               if (eval_error_i) begin
                  state_next  = ST_DONE;
                  result_next = RES_ERROR;
               end else if (eval_winx_i) begin
                  state_next  = ST_DONE;
                  result_next = RES_X_WIN;
               end else if (eval_wino_i) begin
                  state_next  = ST_DONE;
                  result_next = RES_O_WIN;
               end else if (eval_full_i) begin
                  state_next  = ST_DONE;
                  result_next = RES_DRAW;
               end else begin
                  state_next = ST_TURN;
                  turn_next  = ~turn_reg;
               end
            end
            ST_DONE: ;
            default: state_next = ST_IDLE;
         endcase
      end
   end

   assign move_reject_o = reject_reg;
   assign x_board_o     = x_board_reg;
   assign o_board_o     = o_board_reg;
   assign turn_o        = turn_reg;
   assign move_cnt_o    = move_cnt_reg;
   assign game_over_o   = (state_reg == ST_DONE);
   assign result_o      = result_reg;

endmodule

// File: tb/tb_tic_tac_game_ctrl.sv
// tb_tic_tac_game_ctrl: scoreboard bench for tic_tac_game_ctrl with a
// behavioural board evaluator attached (plus override knobs for priority tests).
module tb_tic_tac_game_ctrl;
   import tic_tac_pkg::*;

   localparam int TMO = 5;

   localparam logic [1:0] K_READY  = 2'd0;
   localparam logic [1:0] K_REJECT = 2'd1;
   localparam logic [1:0] K_DONE   = 2'd2;

   typedef struct packed {
      logic [1:0] kind;
      logic       turn;
      logic [8:0] x;
      logic [8:0] o;
      logic [3:0] cnt;
      logic [2:0] res;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_i = 1'b1;
   logic       start_i = 1'b0;
   logic       move_valid_i = 1'b0;
   logic [3:0] move_pos_i = 4'd0;
   logic       move_ready_o, move_reject_o, turn_o, game_over_o;
   logic [8:0] x_board_o, o_board_o;
   logic [3:0] move_cnt_o;
   logic [2:0] result_o;
   logic       eval_error, eval_full, eval_winx, eval_wino;
   logic       force_err = 1'b0;
   logic       force_winx = 1'b0;

   int   checks = 0;
   int   errors = 0;
   exp_t sb_q[$];

   logic [8:0] mx, mo;
   logic       mturn;
   logic [3:0] mcnt;

   always #5 clk = ~clk;

   tic_tac_game_ctrl #(
      .FIRST_PLAYER  (1'b0),
      .TIMEOUT_CYCLES(TMO),
      .TMR_W         (8)
   ) dut (
      .clk_i        (clk),
      .rst_i        (rst_i),
      .start_i      (start_i),
      .move_valid_i (move_valid_i),
      .move_pos_i   (move_pos_i),
      .move_ready_o (move_ready_o),
      .move_reject_o(move_reject_o),
      .x_board_o    (x_board_o),
      .o_board_o    (o_board_o),
      .eval_error_i (eval_error),
      .eval_full_i  (eval_full),
      .eval_winx_i  (eval_winx),
      .eval_wino_i  (eval_wino),
      .turn_o       (turn_o),
      .move_cnt_o   (move_cnt_o),
      .game_over_o  (game_over_o),
      .result_o     (result_o)
   );

   // Behavioural evaluator
   function automatic logic has_line(input logic [8:0] b);
      logic [8:0] lines [8];
      logic       hit;
      lines = '{9'h007, 9'h038, 9'h1C0, 9'h049, 9'h092, 9'h124, 9'h111, 9'h054};
      hit = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if ((b & lines[i]) == lines[i]) hit = 1'b1;
      end
      return hit;
   endfunction

   always_comb begin
      eval_error = ((x_board_o & o_board_o) != 9'd0) || force_err;
      eval_winx  = has_line(x_board_o) || force_winx;
      eval_wino  = has_line(o_board_o);
      eval_full  = ((x_board_o | o_board_o) == 9'h1FF);
   end

   function automatic exp_t mk(input logic [1:0] k, input logic t, input logic [8:0] x,
                               input logic [8:0] o, input logic [3:0] c, input logic [2:0] r);
      exp_t e;
      e.kind = k; e.turn = t; e.x = x; e.o = o; e.cnt = c; e.res = r;
      return e;
   endfunction

   task automatic check(input string name, input int act, input int expv);
      checks++;
      if (act != expv) begin
         errors++;
         $display("FAIL %s got=%0d expected=%0d", name, act, expv);
      end
   endtask

   // Monitor: pops the scoreboard whenever the DUT presents an event
   logic prev_ready = 1'b0;
   logic prev_go = 1'b0;

   task automatic sb_event(input logic [1:0] k);
      exp_t act, e;
      act = mk(k, turn_o, x_board_o, o_board_o, move_cnt_o, result_o);
      checks++;
      if (sb_q.size() == 0) begin
         errors++;
         $display("FAIL unexpected_event kind=%0d turn=%0d x=%h o=%h cnt=%0d res=%0d",
                  k, turn_o, x_board_o, o_board_o, move_cnt_o, result_o);
      end else begin
         e = sb_q.pop_front();
         if (act != e) begin
            errors++;
            $display("FAIL event got kind=%0d turn=%0d x=%h o=%h cnt=%0d res=%0d expected kind=%0d turn=%0d x=%h o=%h cnt=%0d res=%0d",
                     act.kind, act.turn, act.x, act.o, act.cnt, act.res,
                     e.kind, e.turn, e.x, e.o, e.cnt, e.res);
         end else begin
            $display("event kind=%0d turn=%0d x=%h o=%h cnt=%0d res=%0d ok",
                     act.kind, act.turn, act.x, act.o, act.cnt, act.res);
         end
      end
   endtask

   always @(negedge clk) begin
      if (!rst_i) begin
         if (move_reject_o) sb_event(K_REJECT);
         if (game_over_o && !prev_go) sb_event(K_DONE);
         if (move_ready_o && !prev_ready) sb_event(K_READY);
      end
      prev_ready = move_ready_o;
      prev_go    = game_over_o;
   end

   // Stimulus helpers (inputs change 1 time unit after the rising edge)
   task automatic start_game(input logic with_move);
      start_i      = 1'b1;
      move_valid_i = with_move;
      move_pos_i   = 4'd0;
      sb_q.push_back(mk(K_READY, 1'b0, 9'd0, 9'd0, 4'd0, RES_NONE));
      @(posedge clk); #1;
      start_i      = 1'b0;
      move_valid_i = 1'b0;
      mx = '0; mo = '0; mturn = 1'b0; mcnt = '0;
   endtask

   task automatic wait_ready();
      int n;
      n = 0;
      while (!move_ready_o && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      check("ready_wait", int'(move_ready_o), 1);
   endtask

   task automatic offer(input logic [3:0] pos);
      wait_ready();
      move_valid_i = 1'b1;
      move_pos_i   = pos;
      @(posedge clk); #1;
      move_valid_i = 1'b0;
   endtask

   task automatic place(input logic [3:0] pos);
      if (mturn) mo = mo | (9'd1 << pos);
      else       mx = mx | (9'd1 << pos);
      mcnt = mcnt + 4'd1;
   endtask

   // A legal move that continues the game
   task automatic move_ok(input logic [3:0] pos);
      offer(pos);
      place(pos);
      mturn = ~mturn;
      sb_q.push_back(mk(K_READY, mturn, mx, mo, mcnt, RES_NONE));
   endtask

   task automatic move_bad(input logic [3:0] pos);
      offer(pos);
      sb_q.push_back(mk(K_REJECT, mturn, mx, mo, mcnt, RES_NONE));
   endtask

   // Game-ending move with hand-computed final state
   task automatic move_end(input logic [3:0] pos, input logic [2:0] res,
                           input logic [8:0] ex, input logic [8:0] eo, input logic [3:0] ec);
      int n;
      offer(pos);
      place(pos);
      sb_q.push_back(mk(K_DONE, mturn, ex, eo, ec, res));
      n = 0;
      while (!game_over_o && n < 10) begin
         @(posedge clk); #1;
         n++;
      end
      check("game_over_wait", int'(game_over_o), 1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ready"},  int'(move_ready_o), 0);
      check({tag, "_reject"}, int'(move_reject_o), 0);
      check({tag, "_x"},      int'(x_board_o), 0);
      check({tag, "_o"},      int'(o_board_o), 0);
      check({tag, "_turn"},   int'(turn_o), 0);
      check({tag, "_cnt"},    int'(move_cnt_o), 0);
      check({tag, "_over"},   int'(game_over_o), 0);
      check({tag, "_result"}, int'(result_o), 0);
   endtask

   initial begin
      mx = '0; mo = '0; mturn = 1'b0; mcnt = '0;

      // Reset state
      #2;
      check_reset_outputs("reset");
      @(posedge clk); #1;
      rst_i = 1'b0;
      @(posedge clk); #1;
      check("idle_ready", int'(move_ready_o), 0);

      // X wins on the top row: X 0,1,2 / O 3,4
      start_game(1'b0);
      move_ok(0); move_ok(3); move_ok(1); move_ok(4);
      move_end(2, RES_X_WIN, 9'h007, 9'h018, 4'd5);
      repeat (3) @(posedge clk);
      #1 check("done_hold_result", int'(result_o), 1);

      // Draw: X 0,2,3,7,8 / O 1,4,5,6
      start_game(1'b0);
      move_ok(0); move_ok(1); move_ok(2); move_ok(4);
      move_ok(3); move_ok(5); move_ok(7); move_ok(6);
      move_end(8, RES_DRAW, 9'h18D, 9'h072, 4'd9);

      // Illegal moves: occupied cell, then out-of-range position
      start_game(1'b0);
      move_ok(4);
      move_bad(4);
      move_bad(12);
      // Restart mid-game with a move offered in the same cycle: move dropped
      start_game(1'b1);
      check("restart_x", int'(x_board_o), 0);
      check("restart_turn", int'(turn_o), 0);

      // Asynchronous reset while in CHECK
      offer(0);
      rst_i = 1'b1;
      #1;
      check_reset_outputs("async_reset");
      @(posedge clk); #1;
      rst_i = 1'b0;

      // Error has priority over an X win
      force_err  = 1'b1;
      force_winx = 1'b1;
      start_game(1'b0);
      move_end(0, RES_ERROR, 9'h001, 9'h000, 4'd1);
      force_err  = 1'b0;
      force_winx = 1'b0;

      // Timeout with no moves: DONE exactly TMO cycles after entering TURN
      start_game(1'b0);
      sb_q.push_back(mk(K_DONE, 1'b0, 9'd0, 9'd0, 4'd0, RES_TIMEOUT_X));
      for (int i = 0; i < TMO - 1; i++) begin
         @(posedge clk); #1;
         check("tmo_not_yet", int'(game_over_o), 0);
      end
      @(posedge clk); #1;
      check("tmo_done", int'(game_over_o), 1);
      check("tmo_result", int'(result_o), 5);

      // Move on the last allowed cycle wins; then O times out
      start_game(1'b0);
      repeat (TMO - 1) begin
         @(posedge clk); #1;
      end
      move_ok(0);
      check("last_cycle_move_over", int'(game_over_o), 0);
      check("last_cycle_move_x", int'(x_board_o), 1);
      sb_q.push_back(mk(K_DONE, 1'b1, 9'h001, 9'h000, 4'd1, RES_TIMEOUT_O));

      // Drain the scoreboard
      for (int i = 0; i < 100 && sb_q.size() != 0; i++) begin
         @(posedge clk);
      end
      @(posedge clk); #1;
      check("scoreboard_drained", sb_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/tic_tac_game_ctrl.md
Name: tic_tac_game_ctrl

Overview:
Sequential game controller that sits directly upstream of the tictactoe board evaluator. It accepts one move per handshake, alternates X/O turns and holds the 9-cell board in registers. It drives the evaluator's x/o board inputs and consumes its error/full/winX/winO results to decide game end. It also enforces an optional per-turn move timeout.

Parameters:
FIRST_PLAYER, 0, player moving first after start (0 = X, 1 = O)
TIMEOUT_CYCLES, 0, max cycles a turn may wait for a move; 0 disables timeout
TMR_W, 16, width of turn timer counter (must hold TIMEOUT_CYCLES)

Ports:
clk_i  input  1  clock, all state on rising edge
rst_i  input  1  asynchronous active-high reset
start_i  input  1  pulse: clear board and begin a new game (accepted in any state)
move_valid_i  input  1  move offered this cycle
move_pos_i  input  4  cell index 0..8 (row*3+col, bit index into board vectors)
move_ready_o  output  1  controller accepts a move this cycle
move_reject_o  output  1  one-cycle pulse: accepted move was illegal, turn unchanged
x_board_o  output  9  X occupancy, wired to evaluator x
o_board_o  output  9  O occupancy, wired to evaluator o
eval_error_i  input  1  evaluator error
eval_full_i  input  1  evaluator full
eval_winx_i  input  1  evaluator winX
eval_wino_i  input  1  evaluator winO
turn_o  output  1  player to move (0 = X, 1 = O); valid in turn states
move_cnt_o  output  4  legal moves placed this game (0..9)
game_over_o  output  1  high while in DONE
result_o  output  3  result code from package, valid when game_over_o

Behaviour:
- Reset values: state IDLE; boards 0; move_cnt_o 0; turn_o = FIRST_PLAYER; move_ready_o 0; move_reject_o 0; game_over_o 0; result_o RES_NONE; timer 0.
- States: IDLE, TURN, CHECK, DONE.
- IDLE: waits for start_i.
- start_i in any state has highest priority. Next edge: boards cleared, move_cnt 0, turn = FIRST_PLAYER, timer 0, state TURN. A move offered in the same cycle is dropped.
- move_ready_o = (state==TURN) & ~start_i.
- Handshake: a move is consumed when move_valid_i & move_ready_o.
- Legal move: pos ≤ 8 and cell empty in both boards.
  - Next edge: set the bit in the current player's board, increment move_cnt, go to CHECK.
- Illegal move (pos 9..15 or cell occupied):
  - Consumed. move_reject_o pulses high the following cycle.
  - Board, turn and state unchanged. Timer is not reset.
- CHECK is exactly one cycle; evaluator outputs sampled there. Priority:
  1. eval_error_i → DONE, RES_ERROR
  2. eval_winx_i → DONE, RES_X_WIN
  3. eval_wino_i → DONE, RES_O_WIN
  4. eval_full_i → DONE, RES_DRAW
  5. otherwise → TURN with turn toggled, timer 0
- Move-to-next-ready latency: 2 cycles (accept edge, CHECK edge).
- Timer (TIMEOUT_CYCLES>0):
  - Counts every cycle in TURN without a consumed legal move; cleared on entry to TURN.
  - When timer reaches TIMEOUT_CYCLES−1 with no move consumed that cycle → DONE, RES_TIMEOUT_X or RES_TIMEOUT_O (the timed-out player forfeits).
  - A move consumed in that same cycle wins over the timeout.
- DONE: game_over_o=1, result_o held, boards held. Only start_i or reset leaves.
- Reset mid-game: immediate return to reset values; no partial board retained.
- move_cnt_o saturates at 9. The board outputs change only on the accept edge, start or reset.

Decomposition:
- Package tic_tac_pkg:
  - state enum {ST_IDLE, ST_TURN, ST_CHECK, ST_DONE}
  - result enum (3 bits): RES_NONE=0, RES_X_WIN=1, RES_O_WIN=2, RES_DRAW=3, RES_ERROR=4, RES_TIMEOUT_X=5, RES_TIMEOUT_O=6
  - constants BOARD_CELLS=9, PLAYER_X=0, PLAYER_O=1
- Sub-module tic_tac_turn_timer (clk_i, rst_i, clear, enable, expired) isolates the timeout counter. It is tied off when TIMEOUT_CYCLES=0.
- The evaluator is instantiated alongside in the enclosing top, not inside this block.

Test Plan:
- Reset, start_i, X moves 0,1,2 and O moves 3,4 alternately (evaluator attached) → after X's pos 2, CHECK yields result_o=1, game_over_o=1, x_board_o=9'h007, o_board_o=9'h018, move_cnt_o=5.
- Full draw sequence X:0,2,3,7,8 and O:1,4,5,6 → result_o=3, move_cnt_o=9, x_board_o=9'h18D, o_board_o=9'h072.
- After X plays 4, O offers pos 4, then pos 12 → two move_reject_o pulses, turn_o stays 1, boards unchanged, move_cnt_o=1.
- TIMEOUT_CYCLES=5, start, no moves → DONE exactly 5 cycles after entering TURN with result_o=5. Repeat with a move in the 5th cycle → move accepted, no timeout.
- Mid-game: start_i asserted with move_valid_i → move dropped, boards 0, turn_o=FIRST_PLAYER. Assert rst_i mid-CHECK → all outputs at reset values asynchronously.
- Evaluator stub forces eval_error_i=1 and eval_winx_i=1 together in CHECK → result_o=4 (error priority).
